// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle fetch/decode/execute controller owning pc, flags and retired count
module cpu_sequencer #(
  parameter int          PC_WIDTH  = 8,
  parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                run,
  output logic                mem_en,
  output logic                mem_rw,
  output logic [15:0]         mem_addr,
  input  logic [31:0]         mem_rdata,
  output logic [3:0]          rb_dst,
  output logic [3:0]          rb_src1,
  output logic [3:0]          rb_src2,
  output logic                rb_we,
  output logic [3:0]          alu_cond,
  output logic [3:0]          alu_opcode,
  output logic                alu_s,
  output logic [4:0]          alu_iv,
  output logic [3:0]          alu_flag,
  input  logic [3:0]          alu_new_flag,
  output logic                ldr_go,
  output logic                str_go,
  output logic [PC_WIDTH-1:0] pc,
  output logic                busy,
  output logic                halted,
  output logic [15:0]         retired
);
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, DECODE, EXEC, MEM, WB, HALTED} state_t;
  state_t state, nxt;
  logic [31:0] ir;
  logic [3:0] flag;
  logic cond_ok;
  logic is_mem, is_str;
  logic [15:0] cond_tab;
  assign is_mem = &ir[27:25];
  assign is_str = &ir[27:24];
  // one bit per condition code, flag = {N,Z,C,V}
  assign cond_tab = {2'b11, 6'b0, ~flag[0], flag[0], ~flag[3], flag[3],
                     ~flag[1], flag[1], ~flag[2], flag[2]};
  always_comb begin
    nxt = state;
    case (state)
      IDLE, HALTED: nxt = run ? FETCH : state;
      FETCH:        nxt = WAIT;
      WAIT:         nxt = DECODE;
      DECODE:       nxt = ir == HALT_WORD ? HALTED : EXEC;
      EXEC:         nxt = cond_ok && is_mem ? MEM : WB;
      MEM:          nxt = WB;
      WB:           nxt = FETCH;
      default:      nxt = IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      pc      <= '0;
      flag    <= '0;
      ir      <= '0;
      retired <= '0;
      cond_ok <= 1'b0;
    end else begin
      state <= nxt;
      if (state == WAIT) ir <= mem_rdata;
      if (state == DECODE) cond_ok <= cond_tab[ir[31:28]];
      if (state == EXEC && cond_ok && !is_mem && ir[23]) flag <= alu_new_flag;
      if (state == WB) begin
        pc      <= pc + 1'b1;
        retired <= retired + 1'b1;
      end
    end
  end
  assign mem_en     = state == FETCH;
  assign mem_rw     = 1'b0;
  assign mem_addr   = 16'(pc);
  assign rb_we      = state == WB && cond_ok && !is_str;
  assign ldr_go     = state == MEM && !ir[24];
  assign str_go     = state == MEM && ir[24];
  assign busy       = !(state == IDLE || state == HALTED);
  assign halted     = state == HALTED;
  assign alu_cond   = ir[31:28];
  assign alu_opcode = ir[27:24];
  assign alu_s      = ir[23];
  assign rb_dst     = ir[22:19];
  assign rb_src2    = ir[18:15];
  assign rb_src1    = ir[14:11];
  assign alu_iv     = ir[10:6];
  assign alu_flag   = flag;
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed and random programs checked against an instruction-level model
module tb_cpu_sequencer;
  localparam logic [31:0] HALT = 32'hFFFFFFFF;
  localparam logic [6:0] P_BUSY = 7'b0100000, P_HALT = 7'b0010000, P_FET = 7'b0001000,
                         P_WE = 7'b0000100, P_LDR = 7'b0000010, P_STR = 7'b0000001;
  logic Clk = 0, Reset = 0, run = 0;
  logic [31:0] mem_rdata = '0;
  logic mem_en, mem_rw, rb_we, ldr_go, str_go, busy, halted, alu_s;
  logic [15:0] mem_addr, retired;
  logic [3:0] rb_dst, rb_src1, rb_src2, alu_cond, alu_opcode, alu_flag, alu_new_flag;
  logic [4:0] alu_iv;
  logic [7:0] pc;
  logic [31:0] ram [256];
  int tests = 0, fails = 0;
  int exp_tr [4096];
  int obs_tr [4096];
  int exp_len = 0;
  logic [7:0] m_pc;
  logic [3:0] m_flag;
  logic [15:0] m_ret;
  logic [31:0] m_ir;

  cpu_sequencer dut (
    .Clk(Clk), .Reset(Reset), .run(run), .mem_en(mem_en), .mem_rw(mem_rw),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .rb_dst(rb_dst), .rb_src1(rb_src1),
    .rb_src2(rb_src2), .rb_we(rb_we), .alu_cond(alu_cond), .alu_opcode(alu_opcode),
    .alu_s(alu_s), .alu_iv(alu_iv), .alu_flag(alu_flag), .alu_new_flag(alu_new_flag),
    .ldr_go(ldr_go), .str_go(str_go), .pc(pc), .busy(busy), .halted(halted),
    .retired(retired)
  );

  always #5 Clk = ~Clk;
  // ALU stand-in: new flags are a fixed function of the decoded fields
  assign alu_new_flag = alu_iv[3:0] ^ alu_opcode;
  always @(posedge Clk) if (mem_en && !mem_rw) mem_rdata <= ram[mem_addr[7:0]];

  function automatic logic [31:0] pack();
    return {mem_addr, rb_dst, alu_flag, mem_rw, busy, halted, mem_en, rb_we, ldr_go, str_go, 1'b0};
  endfunction

  function automatic void push(logic [6:0] b);
    if (exp_len < 4096) exp_tr[exp_len] = {8'h00, m_pc, m_ir[22:19], m_flag, b, 1'b0};
    exp_len++;
  endfunction

  function automatic bit cond_pass(logic [3:0] f, logic [3:0] c);
    bit n = f[3], z = f[2], cy = f[1], v = f[0];
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'hE, 4'hF: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Instruction-level model: emits the expected per-cycle trace until HALT
  function automatic void model_run();
    logic [31:0] w;
    logic [3:0] op;
    bit pass;
    exp_len = 0;
    for (int k = 0; k < 400; k++) begin
      w = ram[m_pc];
      push(P_BUSY | P_FET);
      push(P_BUSY);
      m_ir = w;
      push(P_BUSY);
      if (w == HALT) begin
        push(P_HALT);
        return;
      end
      pass = cond_pass(m_flag, w[31:28]);
      op = w[27:24];
      push(P_BUSY);
      if (pass && op >= 4'hE) push(P_BUSY | (op == 4'hE ? P_LDR : P_STR));
      else if (pass && w[23]) m_flag = w[9:6] ^ op;
      push(P_BUSY | ((pass && op != 4'hF) ? P_WE : 7'b0));
      m_pc++;
      m_ret++;
    end
  endfunction

  function automatic int first_diff();
    for (int i = 0; i < exp_len; i++) if (obs_tr[i] != exp_tr[i]) return i;
    return -1;
  endfunction

  function automatic int count_bit(int b);
    int c = 0;
    for (int i = 0; i < exp_len; i++) c += obs_tr[i][b];
    return c;
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w = $urandom;
    w[31:28] = 4'($urandom_range(0, 15));
    if (w == HALT) w[0] = 1'b0;
    return w;
  endfunction

  task automatic fill(logic [31:0] w);
    for (int i = 0; i < 256; i++) ram[i] = w;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1;
    @(negedge Clk);
    Reset = 0;
    m_pc = 0; m_flag = 0; m_ret = 0; m_ir = 0;
  endtask

  task automatic do_run();
    @(negedge Clk);
    run = 1;
    @(negedge Clk);
    run = 0;
    obs_tr[0] = pack();
    for (int i = 1; i < exp_len && i < 4096; i++) begin
      @(negedge Clk);
      obs_tr[i] = pack();
    end
  endtask

  task automatic test_reset();
    int d;
    fill(HALT);
    @(negedge Clk);
    Reset = 1;
    run = 1;
    @(negedge Clk);
    Reset = 0;
    run = 0;
    m_pc = 0; m_flag = 0; m_ret = 0; m_ir = 0;
    @(negedge Clk);
    tests++;
    if (pack() !== 32'h0) begin
      fails++;
      $display("FAIL reset_outputs: got %h expected %h", pack(), 32'h0);
    end
    tests++;
    if (pc !== 8'h00 || retired !== 16'h0) begin
      fails++;
      $display("FAIL reset_counters: pc=%h retired=%h expected 00/0000", pc, retired);
    end
    d = {rb_src1, rb_src2, alu_cond, alu_opcode, alu_s, alu_iv};
    tests++;
    if (d !== 0) begin
      fails++;
      $display("FAIL reset_fields: got %h expected 0", d);
    end
  endtask

  task automatic test_basic();
    int d;
    do_reset();
    fill(HALT);
    ram[0] = 32'hE2000000;
    model_run();
    do_run();
    d = first_diff();
    tests++;
    if (d >= 0) begin
      fails++;
      $display("FAIL basic_trace cycle %0d: got %h expected %h", d, obs_tr[d], exp_tr[d]);
    end
    tests++;
    if (count_bit(3) != 1 || obs_tr[4][3] !== 1'b1) begin
      fails++;
      $display("FAIL basic_rb_we: pulses=%0d at5=%b expected 1/1", count_bit(3), obs_tr[4][3]);
    end
    tests++;
    if ({halted, pc, retired} !== {1'b1, 8'h01, 16'h0001}) begin
      fails++;
      $display("FAIL basic_final: halted=%b pc=%h retired=%h expected 1/01/0001", halted, pc, retired);
    end
  endtask

  task automatic test_flag_update();
    int d;
    do_reset();
    fill(HALT);
    ram[0] = 32'hE2800180;
    ram[1] = 32'h02000000;
    model_run();
    do_run();
    d = first_diff();
    tests++;
    if (d >= 0) begin
      fails++;
      $display("FAIL flag_trace cycle %0d: got %h expected %h", d, obs_tr[d], exp_tr[d]);
    end
    tests++;
    if (alu_flag !== 4'b0100) begin
      fails++;
      $display("FAIL flag_value: got %b expected 0100", alu_flag);
    end
    tests++;
    if (count_bit(3) != 2 || obs_tr[9][3] !== 1'b1) begin
      fails++;
      $display("FAIL flag_eq_wb: pulses=%0d at10=%b expected 2/1", count_bit(3), obs_tr[9][3]);
    end
  endtask

  task automatic test_cond_fail();
    int d;
    do_reset();
    fill(HALT);
    ram[0] = 32'h02000000;
    model_run();
    do_run();
    d = first_diff();
    tests++;
    if (d >= 0) begin
      fails++;
      $display("FAIL cfail_trace cycle %0d: got %h expected %h", d, obs_tr[d], exp_tr[d]);
    end
    tests++;
    if (count_bit(3) != 0 || obs_tr[5][4] !== 1'b1) begin
      fails++;
      $display("FAIL cfail_timing: rb_we=%0d fetch5=%b expected 0/1", count_bit(3), obs_tr[5][4]);
    end
    tests++;
    if ({pc, retired} !== {8'h01, 16'h0001}) begin
      fails++;
      $display("FAIL cfail_counters: pc=%h retired=%h expected 01/0001", pc, retired);
    end
  endtask

  task automatic test_ldr_str();
    int d, overlap = 0;
    do_reset();
    fill(HALT);
    ram[0] = 32'hEE000000;
    ram[1] = 32'hEF000000;
    model_run();
    do_run();
    d = first_diff();
    tests++;
    if (d >= 0) begin
      fails++;
      $display("FAIL ldst_trace cycle %0d: got %h expected %h", d, obs_tr[d], exp_tr[d]);
    end
    tests++;
    if ({obs_tr[4][2], obs_tr[5][3], obs_tr[6][4], obs_tr[10][1], obs_tr[11][3], obs_tr[12][4]} !== 6'b111101) begin
      fails++;
      $display("FAIL ldst_timing: got %b expected 111101",
               {obs_tr[4][2], obs_tr[5][3], obs_tr[6][4], obs_tr[10][1], obs_tr[11][3], obs_tr[12][4]});
    end
    for (int i = 0; i < exp_len; i++) if ($countones(obs_tr[i][4:1]) > 1) overlap++;
    tests++;
    if (overlap != 0 || count_bit(3) != 1) begin
      fails++;
      $display("FAIL ldst_strobes: overlaps=%0d rb_we=%0d expected 0/1", overlap, count_bit(3));
    end
  endtask

  task automatic test_random();
    int d, len;
    for (int it = 0; it < 4; it++) begin
      do_reset();
      fill(HALT);
      len = $urandom_range(2, 25);
      for (int i = 0; i < len; i++) ram[i] = rand_word();
      for (int pass_n = 0; pass_n < 2; pass_n++) begin
        if (pass_n == 1) begin
          ram[m_pc] = rand_word();
          ram[8'(m_pc + 8'd1)] = rand_word();
          ram[8'(m_pc + 8'd2)] = HALT;
        end
        model_run();
        do_run();
        d = first_diff();
        tests++;
        if (d >= 0) begin
          fails++;
          $display("FAIL rand_trace it%0d/%0d cycle %0d: got %h expected %h", it, pass_n, d, obs_tr[d], exp_tr[d]);
        end
        tests++;
        if ({halted, pc, retired, alu_flag} !== {1'b1, m_pc, m_ret, m_flag}) begin
          fails++;
          $display("FAIL rand_final it%0d/%0d: got %h expected %h", it, pass_n,
                   {halted, pc, retired, alu_flag}, {1'b1, m_pc, m_ret, m_flag});
        end
      end
    end
  endtask

  task automatic test_pc_wrap();
    int d;
    do_reset();
    fill(32'hE2000000);
    ram[1] = HALT;
    model_run();
    do_run();
    ram[1] = 32'hE2000000;
    ram[0] = HALT;
    model_run();
    do_run();
    d = first_diff();
    tests++;
    if (d >= 0) begin
      fails++;
      $display("FAIL wrap_trace cycle %0d: got %h expected %h", d, obs_tr[d], exp_tr[d]);
    end
    tests++;
    if ({obs_tr[1274][31:16], obs_tr[1275][31:16], obs_tr[1275][4]} !== {16'h00FF, 16'h0000, 1'b1}) begin
      fails++;
      $display("FAIL wrap_addr: wb=%h fetch=%h en=%b expected 00FF/0000/1",
               obs_tr[1274][31:16], obs_tr[1275][31:16], obs_tr[1275][4]);
    end
    tests++;
    if ({pc, retired} !== {8'h00, 16'd256}) begin
      fails++;
      $display("FAIL wrap_final: pc=%h retired=%0d expected 00/256", pc, retired);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    fill(HALT);
    ram[0] = 32'hE2800180;
    ram[1] = 32'hEE000000;
    @(negedge Clk);
    run = 1;
    @(negedge Clk);
    run = 0;
    repeat (9) @(negedge Clk);
    tests++;
    if ({ldr_go, alu_flag, pc} !== {1'b1, 4'b0100, 8'h01}) begin
      fails++;
      $display("FAIL mid_pre: ldr=%b flag=%b pc=%h expected 1/0100/01", ldr_go, alu_flag, pc);
    end
    Reset = 1;
    run = 1;
    @(negedge Clk);
    Reset = 0;
    run = 0;
    tests++;
    if ({ldr_go, str_go, rb_we, busy, halted, pc, alu_flag} !== 17'h0) begin
      fails++;
      $display("FAIL mid_post: ldr=%b str=%b we=%b busy=%b halted=%b pc=%h flag=%b expected all 0",
               ldr_go, str_go, rb_we, busy, halted, pc, alu_flag);
    end
    @(negedge Clk);
    tests++;
    if ({busy, mem_en, retired} !== 18'h0) begin
      fails++;
      $display("FAIL mid_idle: busy=%b mem_en=%b retired=%h expected 0/0/0000", busy, mem_en, retired);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flag_update();
    test_cond_fail();
    test_ldr_str();
    test_random();
    test_pc_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle fetch/decode/execute controller for the master CPU. It owns the program counter and the flag register. It fetches 32-bit instruction words from the RAM, splits them into the fields consumed by the register bank, MASTER_ALU and memory_control, and steps those blocks through execute, memory and write-back phases. It replaces free-running instruction injection with a deterministic per-instruction state machine.

## Interface
Parameters:
- PC_WIDTH, 8, program counter width; RAM address = zero-extended pc to 16 bits
- HALT_WORD, 32'hFFFFFFFF, instruction word that stops the sequencer

Ports:
- Clk  in  1  system clock, all state updates on rising edge
- Reset  in  1  synchronous, active-high; one clock; overrides all other inputs
- run  in  1  start pulse, sampled in IDLE and HALTED only
- mem_en  out  1  RAM enable
- mem_rw  out  1  RAM direction, 0 read / 1 write
- mem_addr  out  16  RAM address for instruction fetch
- mem_rdata  in  32  RAM read data, valid one cycle after mem_en with mem_rw=0
- rb_dst / rb_src1 / rb_src2  out  4 each  register bank destination and sources
- rb_we  out  1  register bank write strobe
- alu_cond  out  4  ALU condition field
- alu_opcode  out  4  ALU/memory opcode
- alu_s  out  1  flag-update bit
- alu_iv  out  5  immediate/shift value
- alu_flag  out  4  current flag register {N,Z,C,V} to ALU
- alu_new_flag  in  4  flags computed by ALU, valid in EXEC
- ldr_go / str_go  out  1 each  single-cycle strobes to memory_control
- pc  out  PC_WIDTH  program counter
- busy  out  1  high in every state except IDLE and HALTED
- halted  out  1  high in HALTED
- retired  out  16  count of completed instructions, wraps at 16'hFFFF

## Operation
- States: IDLE, FETCH, WAIT, DECODE, EXEC, MEM, WB, HALTED.
- IDLE/HALTED: run=1 goes to FETCH. pc is not cleared, so a restart resumes at the current pc.
- FETCH: mem_en=1, mem_rw=0, mem_addr={0,pc}. Go to WAIT.
- WAIT: latch mem_rdata into the instruction register. Go to DECODE.
- DECODE: drive fields from the instruction register:
  - Cond=[31:28], OpCode=[27:24], S=[23]
  - rb_dst=[22:19], rb_src2=[18:15], rb_src1=[14:11], IV=[10:6]
  - If the word equals HALT_WORD, go to HALTED; pc and retired are not changed.
  - Otherwise evaluate the condition against the flag register and go to EXEC.
- Conditions:
  - 0 Z, 1 !Z, 2 C, 3 !C, 4 N, 5 !N, 6 V, 7 !V
  - 8–D never
  - E and F always
- EXEC:
  - If the condition failed, go straight to WB with no side effects.
  - If OpCode is 4'hE (LDR) or 4'hF (STR), go to MEM.
  - Otherwise, if S=1, load alu_new_flag into the flag register, then go to WB.
- MEM: one-cycle ldr_go (LDR) or str_go (STR) strobe. Go to WB.
- WB:
  - rb_we=1 only if the condition passed and OpCode is not STR.
  - pc increments modulo 2^PC_WIDTH (8'hFF wraps to 8'h00).
  - retired increments, including for condition-failed instructions.
  - Go to FETCH.
- Field outputs hold their last decoded value from DECODE until the next DECODE.

## Timing
- Reset values:
  - state IDLE, pc 0, flag register 4'h0, instruction register 0, retired 0
  - all field outputs 0
  - mem_en, mem_rw, rb_we, ldr_go, str_go, busy, halted all 0
- Latency from FETCH to the next FETCH:
  - ALU instruction: 5 cycles
  - LDR/STR: 6 cycles
  - condition-failed: 5 cycles
  - HALT: 3 cycles from FETCH to HALTED
- Strobes (rb_we, ldr_go, str_go, mem_en) are exactly one cycle wide and never coincide.
- run while busy is ignored. run in the same cycle as Reset is ignored.
- Reset mid-instruction: the next state is IDLE. No pending rb_we or ldr_go/str_go is issued. The flag register clears.
- Flags update only in EXEC with S=1 and the condition passed. The next instruction's DECODE sees the new flags.

## Test plan
- Reset, then run with RAM[0]=32'hE2000000 (always, opcode 2, S=0), RAM[1]=HALT_WORD:
  - one rb_we pulse in cycle 5 after run
  - halted asserted, pc=1, retired=1
- Flag update: RAM[0] has S=1, cond E, and the ALU returns alu_new_flag=4'b0100; RAM[1] has cond 0 (EQ):
  - flag register = 4'b0100
  - second instruction writes back (rb_we=1)
- Condition fail: flag register 0, instruction cond 0 (EQ):
  - no rb_we
  - pc and retired still increment; 5-cycle period
- LDR/STR: RAM[0]=32'hEE000000, RAM[1]=32'hEF000000:
  - ldr_go in cycle 5, rb_we in cycle 6
  - str_go with no rb_we in the second instruction; 6-cycle periods
- pc wrap: preload pc=8'hFF via 255 non-halt instructions:
  - after WB, pc=8'h00 and the next fetch address is 16'h0000
- Reset asserted during MEM of an LDR:
  - no ldr_go the next cycle
  - state IDLE, pc=0, flags=0, busy=0
